// File: rtl/ovl_fire_arb_pkg.sv
// Shared types and constants for the OVL fire arbiter.
package ovl_fire_arb_pkg;

   // Arbiter FSM: wait for a pending record, then hold the offer until accepted.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } arb_state_e;

   // Bit positions inside one checker's fire slice.
   localparam int unsigned FIRE_ASSERT = 0;
   localparam int unsigned FIRE_XCHECK = 1;
   localparam int unsigned FIRE_COVER  = 2;

endpackage

// File: rtl/ovl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module ovl_rr_pick #(
   parameter int unsigned NUM_CHK = 4,
   parameter int unsigned ID_W    = $clog2(NUM_CHK)
) (
   input  logic [NUM_CHK-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [ID_W-1:0]    o_sel,
   output logic               o_any
);

   int unsigned w_idx;

   // Scan NUM_CHK positions starting at ptr; the first hit wins.
   always_comb begin
      o_sel = '0;
      o_any = 1'b0;
      w_idx = 0;
      for (int unsigned k = 0; k < NUM_CHK; k++) begin
         w_idx = 32'(i_ptr) + k;
         if (w_idx >= NUM_CHK) begin
            w_idx = w_idx - NUM_CHK;
         end
         if (!o_any && i_req[w_idx[ID_W-1:0]]) begin
            o_any = 1'b1;
            o_sel = w_idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/ovl_fire_arbiter.sv
// Coalesces per-checker OVL fire vectors into pending records and offers them,
// one at a time and round-robin, on a valid/ready report port.
module ovl_fire_arbiter
   import ovl_fire_arb_pkg::*;
#(
   parameter int unsigned NUM_CHK = 4,
   parameter int unsigned FIRE_W  = 3,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned ID_W    = $clog2(NUM_CHK)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUM_CHK*FIRE_W-1:0] fire_in,
   output logic                      rpt_valid,
   input  logic                      rpt_ready,
   output logic [ID_W-1:0]           rpt_id,
   output logic [FIRE_W-1:0]         rpt_fire,
   output logic [CNT_W-1:0]          rpt_count,
   output logic [NUM_CHK-1:0]        gnt_n,
   output logic                      overflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ID_W-1:0]  ID_LAST = ID_W'(NUM_CHK - 1);

   // Pending records, one per checker.
   logic [FIRE_W-1:0]  r_pend_fire [NUM_CHK];
   logic [CNT_W-1:0]   r_pend_cnt  [NUM_CHK];
   logic [NUM_CHK-1:0] r_pend_v;
   logic               r_overflow;

   // Report channel and arbitration state.
   arb_state_e         r_state;
   logic [ID_W-1:0]    r_ptr;
   logic               r_rpt_valid;
   logic [ID_W-1:0]    r_rpt_id;
   logic [FIRE_W-1:0]  r_rpt_fire;
   logic [CNT_W-1:0]   r_rpt_count;
   logic [NUM_CHK-1:0] r_gnt_n;

   logic [FIRE_W-1:0]  w_pend_fire_d [NUM_CHK];
   logic [CNT_W-1:0]   w_pend_cnt_d  [NUM_CHK];
   logic [NUM_CHK-1:0] w_pend_v_d;
   logic               w_overflow_d;
   logic [ID_W-1:0]    w_sel;
   logic               w_any;
   logic               w_load;
   logic               w_hs;
   logic [ID_W-1:0]    w_ptr_next;

   ovl_rr_pick #(
      .NUM_CHK (NUM_CHK),
      .ID_W    (ID_W)
   ) u_pick (
      .i_req (r_pend_v),
      .i_ptr (r_ptr),
      .o_sel (w_sel),
      .o_any (w_any)
   );

   assign w_load     = (r_state == ST_IDLE) && w_any;
   assign w_hs       = r_rpt_valid && rpt_ready;
   assign w_ptr_next = (r_rpt_id == ID_LAST) ? '0 : r_rpt_id + ID_W'(1);

   // Next pending records. The offered record is moved out of storage when it is
   // loaded, so fires arriving during the offer (including in the handshake cycle)
   // start a fresh record instead of being merged into the report in flight.
   always_comb begin
      w_overflow_d = r_overflow;
      w_pend_v_d   = r_pend_v;
      for (int i = 0; i < NUM_CHK; i++) begin
         w_pend_fire_d[i] = r_pend_fire[i];
         w_pend_cnt_d[i]  = r_pend_cnt[i];
         if (w_load && (w_sel == ID_W'(i))) begin
            w_pend_fire_d[i] = '0;
            w_pend_cnt_d[i]  = '0;
            w_pend_v_d[i]    = 1'b0;
         end
         if (enable && (|fire_in[i*FIRE_W +: FIRE_W])) begin
            w_pend_fire_d[i] = w_pend_fire_d[i] | fire_in[i*FIRE_W +: FIRE_W];
            if (w_pend_cnt_d[i] != CNT_MAX) begin
               w_pend_cnt_d[i] = w_pend_cnt_d[i] + CNT_W'(1);
            end
            w_pend_v_d[i] = 1'b1;
         end
         if (w_pend_cnt_d[i] == CNT_MAX) begin
            w_overflow_d = 1'b1;
         end
      end
   end

   // Pending-record storage and the sticky overflow flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHK; i++) begin
            r_pend_fire[i] <= '0;
            r_pend_cnt[i]  <= '0;
         end
         r_pend_v   <= '0;
         r_overflow <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CHK; i++) begin
            r_pend_fire[i] <= w_pend_fire_d[i];
            r_pend_cnt[i]  <= w_pend_cnt_d[i];
         end
         r_pend_v   <= w_pend_v_d;
         r_overflow <= w_overflow_d;
      end
   end

   // Arbitration FSM: load the picked record, hold it until the handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_rpt_valid <= 1'b0;
         r_rpt_id    <= '0;
         r_rpt_fire  <= '0;
         r_rpt_count <= '0;
         r_gnt_n     <= '1;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_rpt_valid <= 1'b1;
                  r_rpt_id    <= w_sel;
                  r_rpt_fire  <= r_pend_fire[w_sel];
                  r_rpt_count <= r_pend_cnt[w_sel];
                  r_gnt_n     <= ~(NUM_CHK'(1) << w_sel);
                  r_state     <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (w_hs) begin
                  r_rpt_valid <= 1'b0;
                  r_gnt_n     <= '1;
                  r_ptr       <= w_ptr_next;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rpt_valid = r_rpt_valid;
   assign rpt_id    = r_rpt_id;
   assign rpt_fire  = r_rpt_fire;
   assign rpt_count = r_rpt_count;
   assign gnt_n     = r_gnt_n;
   assign overflow  = r_overflow;

endmodule
